// File: rtl/inst_cache_assoc_pkg.sv
// Shared types and address helpers for the set-associative instruction cache.
package inst_cache_assoc_pkg;

    typedef enum logic [2:0] {
        StIdle, StLookup, StMissAr, StMissR, StRefillDone, StUncAr, StUncR, StDrain
    } state_e;

    localparam logic RST_ACTIVE = 1'b0;
    localparam int unsigned WORD_BYTES_W = 2;

    function automatic int unsigned tag_width(int unsigned addr_w, int unsigned index_w,
                                              int unsigned offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int unsigned word_sel_width(int unsigned offset_w);
        return offset_w - WORD_BYTES_W;
    endfunction

    function automatic logic [31:0] line_base(logic [31:0] addr, int unsigned offset_w);
        return (addr >> offset_w) << offset_w;
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// Per-way tag/valid/data storage: one whole-line write port, asynchronous read of all ways.
module icache_way_array
    import inst_cache_assoc_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned WAY_W      = 1,
    parameter int unsigned INDEX_W    = 7,
    parameter int unsigned TAG_W      = 20,
    parameter int unsigned WORD_SEL_W = 3,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [INDEX_W-1:0]                         rd_index,
    input  logic [WORD_SEL_W-1:0]                      rd_word_sel,
    output logic [WAYS-1:0]                            rd_valid,
    output logic [TAG_W-1:0]                           rd_tag  [WAYS],
    output logic [DATA_W-1:0]                          rd_word [WAYS],
    input  logic                                       wr_en,
    input  logic [WAY_W-1:0]                           wr_way,
    input  logic [INDEX_W-1:0]                         wr_index,
    input  logic [TAG_W-1:0]                           wr_tag,
    input  logic [(1<<WORD_SEL_W)-1:0][DATA_W-1:0]     wr_line
);
    localparam int unsigned SETS       = 1 << INDEX_W;
    localparam int unsigned LINE_WORDS = 1 << WORD_SEL_W;

    logic [SETS-1:0]                       valid_q [WAYS];
    logic [TAG_W-1:0]                      tag_q   [WAYS][SETS];
    logic [LINE_WORDS-1:0][DATA_W-1:0]     data_q  [WAYS][SETS];

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            for (int w = 0; w < int'(WAYS); w++) valid_q[w] <= '0;
        end else if (wr_en) begin
            valid_q[wr_way][wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_way][wr_index]  <= wr_tag;
            data_q[wr_way][wr_index] <= wr_line;
        end
    end

    always_comb begin
        for (int w = 0; w < int'(WAYS); w++) begin
            rd_valid[w] = valid_q[w][rd_index];
            rd_tag[w]   = tag_q[w][rd_index];
            rd_word[w]  = data_q[w][rd_index][rd_word_sel];
        end
    end

endmodule

// File: rtl/inst_cache_assoc.sv
// Set-associative instruction cache with round-robin replacement and an uncached bypass.
// ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt lookup counters.
module inst_cache_assoc
    import inst_cache_assoc_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned LINE_OFFSET_W = 5,
    parameter int unsigned INDEX_W       = 7,
    parameter int unsigned WAYS          = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_ena,
    input  logic              flush,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic [ADDR_W-1:0] s_rdata,
    output logic              s_rvalid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ADDR_W-1:0] m_rdata,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    output logic              m_rready
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int unsigned TAG_W      = tag_width(ADDR_W, INDEX_W, LINE_OFFSET_W);
    localparam int unsigned WORD_SEL_W = word_sel_width(LINE_OFFSET_W);
    localparam int unsigned LINE_WORDS = 1 << WORD_SEL_W;
    localparam int unsigned SETS       = 1 << INDEX_W;
    localparam int unsigned WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e                            state;
    logic [ADDR_W-1:0]                 addr_q;
    logic [WORD_SEL_W-1:0]             beat_q;
    logic [LINE_WORDS-1:0][ADDR_W-1:0] line_q;
    logic [LINE_WORDS-1:0][ADDR_W-1:0] line_wr;
    logic [WAY_W-1:0]                  rr_q [SETS];
    logic                              m_arvalid_q;

    logic [TAG_W-1:0]      tag;
    logic [INDEX_W-1:0]    index;
    logic [WORD_SEL_W-1:0] word_sel;
    logic [WAYS-1:0]       way_valid;
    logic [TAG_W-1:0]      way_tag  [WAYS];
    logic [ADDR_W-1:0]     way_word [WAYS];
    logic                  hit;
    logic [ADDR_W-1:0]     hit_word;
    logic [WAY_W-1:0]      victim;
    logic                  alloc;
    logic                  accept;

    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign index    = addr_q[LINE_OFFSET_W +: INDEX_W];
    assign word_sel = addr_q[WORD_BYTES_W +: WORD_SEL_W];

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (way_valid[w] && way_tag[w] == tag) begin
                hit      = 1'b1;
                hit_word = way_word[w];
            end
        end
        // Lowest invalid way wins; round-robin only when the set is full.
        victim = rr_q[index];
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim = WAY_W'(w);
        end
        line_wr         = line_q;
        line_wr[beat_q] = m_rdata;
    end

    assign alloc  = (state == StMissR) && m_rvalid && m_rlast && !flush;
    assign accept = s_arvalid && !flush && (state == StIdle || (state == StLookup && hit));

    assign s_rvalid  = !flush && ((state == StLookup && hit) || state == StRefillDone);
    assign s_rdata   = !s_rvalid ? '0 : (state == StLookup) ? hit_word : line_q[word_sel];
    assign m_arvalid = m_arvalid_q && !flush;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state       <= StIdle;
            addr_q      <= '0;
            beat_q      <= '0;
            m_arvalid_q <= 1'b0;
            m_araddr    <= '0;
            m_arlen     <= '0;
            m_rready    <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StLookup: begin
                    if (accept) begin
                        addr_q <= s_araddr;
                        state  <= cache_ena ? StLookup : StUncAr;
                        if (!cache_ena) begin
                            m_arvalid_q <= 1'b1;
                            m_araddr    <= s_araddr;
                            m_arlen     <= '0;
                        end
                    end else if (state == StLookup && !flush && !hit) begin
                        state       <= StMissAr;
                        m_arvalid_q <= 1'b1;
                        m_araddr    <= line_base(addr_q, LINE_OFFSET_W);
                        m_arlen     <= 8'(LINE_WORDS - 1);
                    end else begin
                        state <= StIdle;
                    end
                end
                StMissAr, StUncAr: begin
                    if (flush) begin
                        state       <= StIdle;
                        m_arvalid_q <= 1'b0;
                    end else if (m_arready) begin
                        m_arvalid_q <= 1'b0;
                        m_rready    <= 1'b1;
                        beat_q      <= '0;
                        state       <= (state == StMissAr) ? StMissR : StUncR;
                    end
                end
                StMissR: begin
                    if (m_rvalid) begin
                        line_q[beat_q] <= m_rdata;
                        beat_q         <= beat_q + 1'b1;
                        if (m_rlast) begin
                            m_rready <= 1'b0;
                            state    <= flush ? StIdle : StRefillDone;
                        end else if (flush) begin
                            state <= StDrain;
                        end
                    end else if (flush) begin
                        state <= StDrain;
                    end
                end
                StUncR: begin
                    if (m_rvalid) begin
                        line_q[word_sel] <= m_rdata;
                        m_rready         <= 1'b0;
                        state            <= flush ? StIdle : StRefillDone;
                    end else if (flush) begin
                        state <= StDrain;
                    end
                end
                StRefillDone: state <= StIdle;
                StDrain: begin
                    if (m_rvalid && m_rlast) begin
                        m_rready <= 1'b0;
                        state    <= StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            for (int s = 0; s < int'(SETS); s++) rr_q[s] <= '0;
        end else if (alloc && &way_valid) begin
            rr_q[index] <= (rr_q[index] == WAY_W'(WAYS - 1)) ? '0 : rr_q[index] + 1'b1;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == StLookup && !flush) begin
            if (hit) hit_cnt <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

    icache_way_array #(
        .WAYS       (WAYS),
        .WAY_W      (WAY_W),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W),
        .WORD_SEL_W (WORD_SEL_W),
        .DATA_W     (ADDR_W)
    ) u_way_array (
        .clk         (clk),
        .rst         (rst),
        .rd_index    (index),
        .rd_word_sel (word_sel),
        .rd_valid    (way_valid),
        .rd_tag      (way_tag),
        .rd_word     (way_word),
        .wr_en       (alloc),
        .wr_way      (victim),
        .wr_index    (index),
        .wr_tag      (tag),
        .wr_line     (line_wr)
    );

endmodule

// File: doc/inst_cache_assoc.md
Name: inst_cache_assoc

Overview:
Parametrised set-associative successor of the direct-mapped instruction cache. It sits between the IF stage (s_* request/response) and the AXI read master (m_* channel).
- Generalises line size, set count and associativity.
- Adds per-set round-robin replacement with invalid-way preference.
- Adds a burst-length output for the AXI bridge.
- Keeps a single-beat uncached path selected by cache_ena.

Parameters:
ADDR_W, 32, address and data width (fixed 32-bit words).
LINE_OFFSET_W, 5, log2 of line bytes; LINE_WORDS = 2^(LINE_OFFSET_W-2).
INDEX_W, 7, log2 of set count.
WAYS, 2, associativity; power of two, 1..8.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets)
cache_ena  in  1  1 = cached access, 0 = uncached single-beat access
flush  in  1  pipeline flush; abort the current request
s_araddr  in  32  fetch address from CPU
s_arvalid  in  1  fetch request valid
s_rdata  out  32  fetched instruction
s_rvalid  out  1  s_rdata valid, one-cycle pulse per request
m_araddr  out  32  read address to bus (line-aligned if cached)
m_arlen  out  8  beats-1: LINE_WORDS-1 cached, 0 uncached
m_arvalid  out  1  read address valid
m_arready  in  1  read address accepted
m_rdata  in  32  read data beat
m_rvalid  in  1  read data valid
m_rlast  in  1  last beat
m_rready  out  1  read data ready

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - All valid bits and round-robin pointers clear.
  - Outputs: s_rvalid=0, s_rdata=0, m_arvalid=0, m_araddr=0, m_arlen=0, m_rready=0.
  - Reset mid-refill abandons the burst without draining it; the bus slave is reset in the same domain.
- Request capture:
  - Request is accepted in IDLE, or in LOOKUP on a hit, when s_arvalid=1 and flush=0.
  - s_araddr and cache_ena are registered on acceptance; later changes on s_araddr have no effect on the in-flight request.
  - Only one request is outstanding at a time.
- States: IDLE, LOOKUP, MISS_AR, MISS_R, REFILL_DONE, UNC_AR, UNC_R, DRAIN.
- LOOKUP (cached):
  - Compare the tag against all WAYS of the indexed set.
  - Hit: s_rvalid=1 combinationally in that cycle with the selected word. Latency is 1 cycle after acceptance.
  - Back-to-back hits sustain 1 fetch per cycle.
  - Miss: go to MISS_AR.
- Victim selection: lowest-numbered invalid way; if all ways are valid, the set's round-robin pointer, which then increments mod WAYS.
- MISS_AR:
  - Drive m_arvalid=1, m_araddr={tag,index,LINE_OFFSET_W zeros}, m_arlen=LINE_WORDS-1.
  - Hold until m_arready=1, then go to MISS_R.
- MISS_R:
  - m_rready=1; each m_rvalid beat is written to the line buffer at a beat counter that starts at 0.
  - On the beat with m_rlast=1: write tag, data and valid=1 into the victim way, then go to REFILL_DONE.
  - m_rlast before LINE_WORDS beats: treat as complete; unreceived words are undefined.
- REFILL_DONE: s_rvalid=1 for one cycle with the requested word, then go to IDLE.
- Uncached path (cache_ena=0 at capture):
  - UNC_AR: full address, m_arlen=0.
  - UNC_R: the m_rdata beat goes to s_rdata with s_rvalid=1 in the cycle after the beat.
  - Nothing is allocated.
- Flush:
  - In IDLE or LOOKUP: drop the request; no s_rvalid is asserted.
  - In MISS_AR before the handshake: drop m_arvalid and go to IDLE.
  - After the AR handshake: go to DRAIN. DRAIN keeps m_rready=1, discards beats, performs no allocation, and returns to IDLE after m_rlast.
  - Flush has priority over a simultaneous s_arvalid.
  - Cache contents are not invalidated by flush.
- No s_rvalid is ever asserted for a flushed request.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Counters increment on cached LOOKUP hit and miss respectively.
  - Counters wrap at 2^32 and clear on reset.
  - Uncached and flushed-in-IDLE requests are not counted.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header:
  - State encodings.
  - Derived widths: TAG_W = 32-INDEX_W-LINE_OFFSET_W, WORD_SEL_W = LINE_OFFSET_W-2.
  - Address field slicing helpers.
  - Reset-polarity constants.
- One sub-module: icache_way_array, holding per-way tag/valid/data storage with one line write port and a read of all ways. The top keeps the FSM, victim selection and bus handshake.

Test Plan:
- Cold miss on 0xf000_0000 (cached): m_araddr=0xf000_0000 and m_arlen=7. The bench returns words 0xf000_0000..0xf000_001c. Required: s_rdata=0xf000_0000, valid 1 cycle after rlast. A following 0xf000_0008 hits with s_rdata=0xf000_0008 in 1 cycle.
- Two-way conflict: fill 0xf100_0004, then 0xf300_0004 (same index); both then hit. A third tag 0xf500_0004 evicts way 0 per round-robin, so 0xf100_0004 misses again and 0xf300_0004 still hits.
- Uncached 0x0200_000c: m_arlen=0 and one beat of 0x0200_000c gives s_rdata=0x0200_000c. A repeat access misses again, since nothing is allocated.
- Flush during MISS_R after beat 3: remaining beats are drained with no s_rvalid. A subsequent access to the same address misses, since the line was not allocated.
- s_araddr changed to 0xffff_ffff one cycle after acceptance of 0xf100_0000: response data is still 0xf100_0000.
- rst=0 asserted mid-burst: the next cycle shows all outputs 0, and the previously filled line misses. With ICACHE_PERF_CNT_EN defined: 3 hits and 2 misses read as hit_cnt=3, miss_cnt=2.
